// File: rtl/count_mod_n.sv
// Purpose: parametrised N-bit modulo counter with up/down, clear/load, enable and wrap/saturate/one-shot end modes.
// Latency: count updates on the enabling edge; wrap/T/busy are registered and reflect the step one cycle later.
// Backpressure: none; en is the only throttle, and a finished one-shot ignores en until clr/load/rst.
module count_mod_n #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256,
  parameter int MODE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             T,
  output logic             busy
);

  typedef enum logic {RUN, DONE} state_t;

  // Highest legal count; MODULUS may equal 2**WIDTH, so MODULUS-1 always fits.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] end_val;
  logic             at_end;
  logic             held;    // saturate mode: end-of-range already reported
  logic             busy_q;
  state_t           state;

  // End of range depends on the current direction, so tc follows up without a clock.
  always_comb begin
    end_val = up ? LAST : '0;
    at_end  = (count == end_val);
  end

  assign tc   = at_end;
  assign busy = (MODE == 2) ? busy_q : 1'b1;

  // Counter, pulse/toggle outputs and one-shot state, in rst > clr > load > en priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wrap   <= 1'b0;
      T      <= 1'b0;
      held   <= 1'b0;
      busy_q <= 1'b1;
      state  <= RUN;
    end else if (clr) begin
      count  <= '0;
      wrap   <= 1'b0;
      held   <= 1'b0;
      busy_q <= 1'b1;
      state  <= RUN;
    end else if (load) begin
      // Out-of-range load values clamp to the top of the range.
      count  <= (load_val > LAST) ? LAST : load_val;
      wrap   <= 1'b0;
      held   <= 1'b0;
      busy_q <= 1'b1;
      state  <= RUN;
    end else if (state == DONE || !en) begin
      wrap <= 1'b0;
    end else if (!at_end) begin
      // Not at end, so neither +1 past LAST nor -1 below 0 can occur.
      count <= up ? count + 1'b1 : count - 1'b1;
      wrap  <= 1'b0;
      held  <= 1'b0;
    end else begin
      case (MODE)
        1: begin
          // Saturate: report reaching the end once, then sit quietly.
          if (!held) begin
            wrap <= 1'b1;
            T    <= ~T;
            held <= 1'b1;
          end else begin
            wrap <= 1'b0;
          end
        end
        2: begin
          wrap   <= 1'b1;
          T      <= ~T;
          busy_q <= 1'b0;
          state  <= DONE;
        end
        default: begin
          count <= up ? '0 : LAST;
          wrap  <= 1'b1;
          T     <= ~T;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_mod_n.sv
// Bench for count_mod_n: five parameterisations share one stimulus stream.
// Each output is compared every cycle against a modular-arithmetic reference model.
// Directed steps cover the listed scenarios, followed by a randomized phase.
module tb_count_mod_n;

  localparam int N = 5;
  localparam int MOD [N] = '{256, 10, 16, 5, 200};
  localparam int MDE [N] = '{0, 0, 1, 2, 0};
  localparam int WID [N] = '{8, 4, 4, 3, 9};

  logic       clk = 1'b0;
  logic       rst, en, up, clr, load;
  logic [8:0] lv;

  logic [7:0] c0;
  logic [3:0] c1;
  logic [3:0] c2;
  logic [2:0] c3;
  logic [8:0] c4;
  logic [N-1:0] otc, ow, ot, ob;
  logic [8:0] oc [N];

  int checks = 0;
  int errors = 0;

  // Reference state per instance.
  int mc [N];
  int mt [N];
  int mw [N];
  int mdone [N];
  int mheld [N];
  int wc [N];

  always #5 clk = ~clk;

  count_mod_n #(.WIDTH(8), .MODULUS(256), .MODE(0)) d0 (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv[7:0]), .count(c0), .tc(otc[0]), .wrap(ow[0]), .T(ot[0]), .busy(ob[0]));
  count_mod_n #(.WIDTH(4), .MODULUS(10), .MODE(0)) d1 (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv[3:0]), .count(c1), .tc(otc[1]), .wrap(ow[1]), .T(ot[1]), .busy(ob[1]));
  count_mod_n #(.WIDTH(4), .MODULUS(16), .MODE(1)) d2 (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv[3:0]), .count(c2), .tc(otc[2]), .wrap(ow[2]), .T(ot[2]), .busy(ob[2]));
  count_mod_n #(.WIDTH(3), .MODULUS(5), .MODE(2)) d3 (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv[2:0]), .count(c3), .tc(otc[3]), .wrap(ow[3]), .T(ot[3]), .busy(ob[3]));
  count_mod_n #(.WIDTH(9), .MODULUS(200), .MODE(0)) d4 (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .load(load), .load_val(lv[8:0]), .count(c4), .tc(otc[4]), .wrap(ow[4]), .T(ot[4]), .busy(ob[4]));

  assign oc[0] = {1'b0, c0};
  assign oc[1] = {5'b0, c1};
  assign oc[2] = {5'b0, c2};
  assign oc[3] = {6'b0, c3};
  assign oc[4] = c4;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mc[i] = 0; mt[i] = 0; mw[i] = 0; mdone[i] = 0; mheld[i] = 0;
    end
  endtask

  // One clock edge of the reference: the range is the integers 0..M-1 taken modulo M.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int m, lvm, stop;
      m     = MOD[i];
      lvm   = int'(lv) % (1 << WID[i]);
      stop  = up ? m - 1 : 0;
      mw[i] = 0;
      if (clr) begin
        mc[i] = 0; mdone[i] = 0; mheld[i] = 0;
      end else if (load) begin
        mc[i] = (lvm > m - 1) ? m - 1 : lvm; mdone[i] = 0; mheld[i] = 0;
      end else if (en && mdone[i] == 0) begin
        if (mc[i] != stop) begin
          mc[i] = (mc[i] + (up ? 1 : m - 1)) % m;
          mheld[i] = 0;
        end else if (MDE[i] == 0) begin
          mc[i] = (mc[i] + (up ? 1 : m - 1)) % m;
          mw[i] = 1; mt[i] ^= 1;
        end else if (MDE[i] == 1) begin
          if (mheld[i] == 0) begin
            mw[i] = 1; mt[i] ^= 1; mheld[i] = 1;
          end
        end else begin
          mw[i] = 1; mt[i] ^= 1; mdone[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("count", i, 32'(oc[i]), mc[i]);
      chk("tc", i, 32'(otc[i]), (up ? (mc[i] == MOD[i] - 1) : (mc[i] == 0)) ? 1 : 0);
      chk("wrap", i, 32'(ow[i]), mw[i]);
      chk("T", i, 32'(ot[i]), mt[i]);
      chk("busy", i, 32'(ob[i]), (MDE[i] == 2) ? (mdone[i] == 0 ? 1 : 0) : 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) if (ow[i] === 1'b1) wc[i]++;
    check_all();
  endtask

  task automatic clear_wc();
    for (int i = 0; i < N; i++) wc[i] = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0; load = 1'b0; lv = '0;
    model_reset();
    clear_wc();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Free-running up count on every instance.
    for (int n = 1; n <= 379; n++) begin
      cyc();
      if (n == 30) begin
        chk("sat_hold", 2, 32'(c2), 15);
        chk("sat_T", 2, 32'(ot[2]), 1);
        chk("sat_wraps", 2, wc[2], 1);
        chk("os_hold", 3, 32'(c3), 4);
        chk("os_busy", 3, 32'(ob[3]), 0);
        chk("os_wraps", 3, wc[3], 1);
      end
      if (n == 255) chk("tc_at_255", 0, 32'(otc[0]), 1);
      if (n == 256) chk("wrap_to_0", 0, 32'(c0), 0);
      if (n == 300) begin
        chk("wraps_300", 0, wc[0], 1);
        chk("T_300", 0, 32'(ot[0]), 1);
      end
    end
    chk("count_123", 0, 32'(c0), 123);
    chk("T_before_rst", 0, 32'(ot[0]), 1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_count", 0, 32'(c0), 0);
    chk("async_T", 0, 32'(ot[0]), 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) cyc();
    chk("resume", 0, 32'(c0), 20);
    chk("os_done", 3, 32'(c3), 4);

    // Saturated counter steps back down; one-shot ignores en.
    up = 1'b0;
    cyc();
    chk("sat_down1", 2, 32'(c2), 14);
    cyc();
    chk("sat_down2", 2, 32'(c2), 13);
    chk("os_ignores_en", 3, 32'(c3), 4);

    // Restart one-shot with clr.
    up = 1'b1; clr = 1'b1;
    cyc();
    chk("os_clr_count", 3, 32'(c3), 0);
    chk("os_clr_busy", 3, 32'(ob[3]), 1);
    clr = 1'b0;
    cyc();
    cyc();
    chk("os_resume", 3, 32'(c3), 2);

    // Non-power-of-2 down count from a loaded value.
    up = 1'b0; en = 1'b0; load = 1'b1; lv = 9'd3;
    cyc();
    chk("load3", 1, 32'(c1), 3);
    load = 1'b0; en = 1'b1;
    clear_wc();
    cyc(); chk("down2", 1, 32'(c1), 2);
    cyc(); chk("down1", 1, 32'(c1), 1);
    cyc(); chk("down0", 1, 32'(c1), 0);
    cyc(); chk("down9", 1, 32'(c1), 9);
    chk("down_wrap", 1, 32'(ow[1]), 1);
    cyc(); chk("down8", 1, 32'(c1), 8);
    chk("down_wraps", 1, wc[1], 1);

    // clr beats load beats en; oversize load clamps.
    clr = 1'b1; load = 1'b1; lv = 9'd7;
    cyc();
    chk("prio_clr", 0, 32'(c0), 0);
    chk("prio_clr", 1, 32'(c1), 0);
    clr = 1'b0; lv = 9'd300;
    cyc();
    chk("clamp", 4, 32'(c4), 199);
    load = 1'b0;

    // Randomized phase checked against the model every cycle.
    for (int n = 0; n < 500; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      clr  = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 29) == 0);
      lv   = 9'($urandom_range(0, 511));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_mod_n.md
Name: count_mod_n

Overview:
- Parametrised successor to the fixed 8-bit free-running counter.
- Provides an N-bit modulo counter with:
  - up/down direction
  - synchronous clear and load
  - count enable
  - three end-of-range modes: wrap, saturate, one-shot
- Emits a terminal-count flag, a registered wrap pulse and a T-style toggle output that flips on every wrap.
- Used as the generic timebase/event counter in later designs.

Parameters:
- WIDTH, 8: counter width in bits.
- MODULUS, 256: count range 0..MODULUS-1. Legal range 2..2**WIDTH.
- MODE, 0:
  - 0 = wrap
  - 1 = saturate (hold at end)
  - 2 = one-shot (stop at end until restarted by clr or load)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  load value
- count  output  WIDTH  registered count
- tc  output  1  combinational terminal count: count at end of range in current direction
- wrap  output  1  registered one-cycle pulse, high the cycle after an end-of-range step
- T  output  1  registered toggle; inverts each time wrap fires
- busy  output  1  MODE 2 only: 1 while running; tied 1 in MODE 0/1

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-count) sets:
  - count=0, wrap=0, T=0, busy=1
  - one-shot FSM to RUN
- Release of rst is synchronised by the user; the block takes no special action.
- Per-edge priority: rst > clr > load > en. Both clr and load clear a pending one-shot DONE and return the FSM to RUN.
- clr: count<=0, wrap<=0. T is unchanged.
- load:
  - count<=load_val if load_val<=MODULUS-1, else count<=MODULUS-1 (clamp).
  - wrap<=0.
- End of range:
  - up=1: end = MODULUS-1.
  - up=0: end = 0.
  - tc = (count==end). tc is independent of en.
- Counting step, applied when en=1 and no clr/load, with count not at end:
  - count<=count+1 if up=1, count-1 if up=0.
  - wrap<=0.
- Step taken when en=1 and count==end:
  - MODE 0: count<=0 (up) or MODULUS-1 (down); wrap<=1; T<=~T.
  - MODE 1: count holds; wrap<=1 on the first such cycle only, then 0 while held at end; T<=~T on that first cycle only.
  - MODE 2: count holds; wrap<=1; T<=~T; FSM RUN->DONE; busy<=0.
- DONE state:
  - en is ignored; count holds.
  - Leaves DONE only via clr, load or rst.
- en=0: count holds; wrap<=0.
- Direction change mid-count: takes effect on the same edge. No glitch; tc re-evaluates combinationally.
- Arithmetic is modulo MODULUS. Non-power-of-2 MODULUS never produces values >= MODULUS.
- Latency:
  - count updates on the edge where en is sampled.
  - wrap/T are valid one cycle after the terminal step.

Test Plan:
- Reset: MODE 0, WIDTH=8, MODULUS=256, en=1, up=1. Run 300 cycles -> count goes 0..255, returns to 0 at cycle 256; wrap high for exactly one cycle; T=1; tc high only while count=255.
- Non-power-of-2 down count: MODULUS=10, up=0, load_val=3 with load pulse, then en=1 -> count sequence 3,2,1,0,9,8. wrap pulses once after the 0->9 step.
- Saturate: MODE 1, MODULUS=16, up=1 from 0 -> count stops at 15 for 10 further cycles. wrap fires once; T toggles once. Then up=0 -> count 14,13.
- One-shot: MODE 2, MODULUS=5 -> count 0..4. busy falls with wrap; en held high for 5 more cycles and count stays 4. Then clr -> count=0, busy=1, counting resumes.
- Priority: clr=1, load=1, load_val=7, en=1 on the same edge -> count=0. load=1, load_val=300 with MODULUS=200 -> count=199.
- Async reset mid-operation: assert rst between clock edges at count=123, T=1 -> count=0 and T=0 immediately, without waiting for clk. After release, counting resumes from 0.
